cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing FSM for one set-associative cache bank: tag lookup, hit response, victim selection, dirty writeback and line fill.
- Drives the PLRU tracker's update strobe, set address and hit vector, and consumes its eviction candidate.
- Sits between the upstream port (ufp, CPU side) and the downstream port (dfp, memory side).
- Tag, data, valid and dirty arrays live in the datapath; this block only drives their enables.

Parameters:
- WAYS, 4, associativity; power of two, >= 2.
- SETS, 16, sets per way; power of two.
- S_INDEX, $clog2(SETS), set index width (localparam).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- ufp_read, input, 1, read request; held until ufp_resp.
- ufp_write, input, 1, write request; held until ufp_resp; mutually exclusive with ufp_read.
- ufp_set, input, S_INDEX, set index of the request; stable while the request is held.
- ufp_resp, output, 1, one-cycle completion pulse.
- way_hit, input, WAYS, per-way valid AND tag match from the datapath.
- way_valid, input, WAYS, valid bits of the addressed set.
- way_dirty, input, WAYS, dirty bits of the addressed set.
- evict_candidate, input, WAYS, one-hot victim from the PLRU.
- plru_update, output, 1, PLRU write enable (active-high).
- plru_hit_vector, output, WAYS, one-hot way just accessed.
- set_addr, output, S_INDEX, set index to all arrays and the PLRU.
- data_we, output, WAYS, store write enable per way.
- fill_we, output, WAYS, fill enable: tag/data written, valid set, dirty cleared.
- dirty_set, output, 1, set dirty bit of the way in data_we.
- dfp_read, output, 1, memory line read; held until dfp_resp.
- dfp_write, output, 1, memory line write of victim; held until dfp_resp.
- dfp_way, output, WAYS, one-hot victim way selected for writeback/fill.
- dfp_resp, input, 1, memory completion pulse.
- multi_hit, output, 1, sticky error flag: more than one bit of way_hit was set.

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE. Reset state IDLE.
- Reset values: all outputs 0; latched set and victim registers 0; multi_hit 0.
- set_addr: equals ufp_set in IDLE, otherwise the set latched when leaving IDLE. Arrays read synchronously, so way_* inputs are valid in COMPARE.
- IDLE: on ufp_read|ufp_write, latch ufp_set and go to COMPARE. No other outputs are asserted.
- COMPARE, hit (|way_hit):
  - ufp_resp=1 and plru_update=1 with plru_hit_vector=way_hit.
  - On a write: data_we=way_hit and dirty_set=1.
  - Next state IDLE. Hit latency is 2 cycles from request to ufp_resp.
- COMPARE, miss:
  - Latch victim=evict_candidate; dfp_way reflects it from the next cycle.
  - If the victim way is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
  - No ufp_resp and no plru_update.
- WRITEBACK: dfp_write=1 until a cycle with dfp_resp=1, then go to ALLOCATE.
- ALLOCATE:
  - dfp_read=1 until dfp_resp.
  - In the dfp_resp cycle, fill_we=victim, then go to COMPARE.
  - The re-lookup hits, so the PLRU update and the store are performed by the normal hit path.
- dfp_read and dfp_write are never asserted together.
- dfp_resp outside WRITEBACK/ALLOCATE is ignored.
- Multi-hot way_hit in COMPARE:
  - Set multi_hit (sticky until rst).
  - Treat it as a hit on the lowest-index hitting way; plru_hit_vector and data_we carry that one bit only.
- Request dropped before ufp_resp: protocol violation, behaviour undefined. The bench asserts this never happens.
- rst asserted mid-operation (any state): next cycle is IDLE with all outputs 0. An outstanding dfp transaction is abandoned, and the memory model is reset too.
- Back-to-back requests: a new request is accepted in IDLE the cycle after ufp_resp. Minimum 2 cycles per hit.

Optional Feature:
- Macro: CACHE_CTRL_PERF_EN.
- Defined: adds 32-bit outputs hit_count, miss_count and wb_count, all reset to 0.
  - hit_count increments on each ufp_resp whose COMPARE was not preceded by a fill of the same request.
  - miss_count increments on each COMPARE to WRITEBACK/ALLOCATE transition.
  - wb_count increments on each dfp_resp in WRITEBACK.
  - Counters saturate at 0xFFFF_FFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Read hit: way_hit=4'b0100 in COMPARE -> ufp_resp 2 cycles after request, plru_update=1, plru_hit_vector=4'b0100, data_we=0.
- Write hit: way_hit=4'b0001 -> data_we=4'b0001, dirty_set=1, ufp_resp same cycle.
- Clean miss: way_hit=0, evict_candidate=4'b1000, way_valid[3]=0 -> dfp_read with dfp_way=4'b1000, no dfp_write. dfp_resp after 5 cycles -> fill_we=4'b1000, then COMPARE hit, then ufp_resp.
- Dirty miss: victim 4'b0010 valid and dirty -> dfp_write until dfp_resp, then dfp_read, then fill_we=4'b0010. Total ufp_resp follows 2 dfp_resp pulses.
- rst asserted during ALLOCATE with dfp_read=1 -> next cycle state IDLE, dfp_read=0, fill_we=0. A new read afterwards completes normally.
- way_hit=4'b0110 -> multi_hit=1 (stays 1), plru_hit_vector=4'b0010. With CACHE_CTRL_PERF_EN: a hit, then a dirty miss -> hit_count=1, miss_count=1, wb_count=1.

Source files
------------

// File: rtl/cache_ctrl.sv
// Sequencing FSM for one set-associative cache bank: lookup, hit, writeback, fill.
// Optional CACHE_CTRL_PERF_EN adds saturating hit/miss/writeback counters.
module cache_ctrl #(
  parameter int  WAYS    = 4,
  parameter int  SETS    = 16,
  localparam int S_INDEX = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ufp_read,
  input  logic               ufp_write,
  input  logic [S_INDEX-1:0] ufp_set,
  output logic               ufp_resp,
  input  logic [WAYS-1:0]    way_hit,
  input  logic [WAYS-1:0]    way_valid,
  input  logic [WAYS-1:0]    way_dirty,
  input  logic [WAYS-1:0]    evict_candidate,
  output logic               plru_update,
  output logic [WAYS-1:0]    plru_hit_vector,
  output logic [S_INDEX-1:0] set_addr,
  output logic [WAYS-1:0]    data_we,
  output logic [WAYS-1:0]    fill_we,
  output logic               dirty_set,
  output logic               dfp_read,
  output logic               dfp_write,
  output logic [WAYS-1:0]    dfp_way,
  input  logic               dfp_resp,
  output logic               multi_hit
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count,
  output logic [31:0]        wb_count
`endif
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e             state_q, state_d;
  logic [S_INDEX-1:0] set_q, set_d;
  logic [WAYS-1:0]    victim_q, victim_d;
  logic               multi_hit_q, multi_hit_d;
  logic [WAYS-1:0]    hit_oh;
  logic               hit_multi;

  // Isolate the lowest set bit so a multi-hot hit acts on a single way.
  assign hit_oh    = way_hit & (~way_hit + WAYS'(1));
  assign hit_multi = |(way_hit & (way_hit - WAYS'(1)));
  assign multi_hit = multi_hit_q;

  always_comb begin
    state_d         = state_q;
    set_d           = set_q;
    victim_d        = victim_q;
    multi_hit_d     = multi_hit_q;
    set_addr        = set_q;
    ufp_resp        = 1'b0;
    plru_update     = 1'b0;
    plru_hit_vector = '0;
    data_we         = '0;
    fill_we         = '0;
    dirty_set       = 1'b0;
    dfp_read        = 1'b0;
    dfp_write       = 1'b0;
    dfp_way         = '0;
    case (state_q)
      IDLE: begin
        set_addr = ufp_set;
        if (ufp_read || ufp_write) begin
          set_d   = ufp_set;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (|way_hit) begin
          ufp_resp        = 1'b1;
          plru_update     = 1'b1;
          plru_hit_vector = hit_oh;
          if (ufp_write) begin
            data_we   = hit_oh;
            dirty_set = 1'b1;
          end
          if (hit_multi) multi_hit_d = 1'b1;
          state_d = IDLE;
        end else begin
          victim_d = evict_candidate;
          state_d  = (|(evict_candidate & way_valid & way_dirty)) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        dfp_way   = victim_q;
        if (dfp_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        dfp_way  = victim_q;
        // The fill lands now; the following COMPARE hits and does PLRU/store.
        if (dfp_resp) begin
          fill_we = victim_q;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      set_q       <= '0;
      victim_q    <= '0;
      multi_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_q       <= set_d;
      victim_q    <= victim_d;
      multi_hit_q <= multi_hit_d;
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;
  logic        filled_q, filled_d;

  // filled_q marks a COMPARE reached via a fill, whose response is not a hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    filled_d   = filled_q;
    if (state_q == IDLE) filled_d = 1'b0;
    if (state_q == ALLOCATE && dfp_resp) filled_d = 1'b1;
    if (ufp_resp && !filled_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == COMPARE && !(|way_hit) && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == WRITEBACK && dfp_resp && wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
      filled_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      filled_q   <= filled_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expected responses,
// monitors pop and compare on ufp_resp, fill_we and writeback completion.
module tb_cache_ctrl;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int SI   = 4;
  localparam int DLY  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ufp_read = 1'b0, ufp_write = 1'b0;
  logic [SI-1:0]   ufp_set = '0;
  logic            ufp_resp;
  logic [WAYS-1:0] way_hit = '0, way_valid = '0, way_dirty = '0, evict_candidate = '0;
  logic            plru_update;
  logic [WAYS-1:0] plru_hit_vector;
  logic [SI-1:0]   set_addr;
  logic [WAYS-1:0] data_we, fill_we, dfp_way;
  logic            dirty_set, dfp_read, dfp_write, multi_hit;
  logic            dfp_resp = 1'b0;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0]     hit_count, miss_count, wb_count;
`endif

  cache_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .ufp_read(ufp_read), .ufp_write(ufp_write), .ufp_set(ufp_set), .ufp_resp(ufp_resp),
    .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
    .evict_candidate(evict_candidate),
    .plru_update(plru_update), .plru_hit_vector(plru_hit_vector), .set_addr(set_addr),
    .data_we(data_we), .fill_we(fill_we), .dirty_set(dirty_set),
    .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_way(dfp_way), .dfp_resp(dfp_resp),
    .multi_hit(multi_hit)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [WAYS-1:0] hv;
    logic [WAYS-1:0] we;
    logic            dirty;
    logic [SI-1:0]   set;
    int              lat;
  } resp_t;

  resp_t           resp_q[$];
  logic [WAYS-1:0] fill_q[$];
  logic [WAYS-1:0] wb_q[$];
  int              req_cyc;
  resp_t           mon_r;
  logic [WAYS-1:0] mon_w;

  // Response / fill / writeback monitor
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ufp_resp) begin
        if (resp_q.size() == 0) chk("unexpected_resp", 32'(ufp_resp), 32'(0));
        else begin
          mon_r = resp_q.pop_front();
          chk("plru_update", 32'(plru_update), 32'(1));
          chk("plru_hit_vector", 32'(plru_hit_vector), 32'(mon_r.hv));
          chk("data_we", 32'(data_we), 32'(mon_r.we));
          chk("dirty_set", 32'(dirty_set), 32'(mon_r.dirty));
          chk("set_addr", 32'(set_addr), 32'(mon_r.set));
          chk("latency", 32'(cyc - req_cyc + 1), 32'(mon_r.lat));
        end
      end
      if (|fill_we) begin
        if (fill_q.size() == 0) chk("unexpected_fill", 32'(fill_we), 32'(0));
        else begin
          mon_w = fill_q.pop_front();
          chk("fill_we", 32'(fill_we), 32'(mon_w));
          chk("fill_dfp_way", 32'(dfp_way), 32'(mon_w));
          chk("fill_no_dfp_write", 32'(dfp_write), 32'(0));
        end
      end
      if (dfp_write && dfp_resp) begin
        if (wb_q.size() == 0) chk("unexpected_writeback", 32'(dfp_way), 32'(0));
        else begin
          mon_w = wb_q.pop_front();
          chk("wb_dfp_way", 32'(dfp_way), 32'(mon_w));
        end
      end
    end
  end

  // Protocol assertions
  logic req_prev = 1'b0, resp_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      assert (!(dfp_read && dfp_write)) else $error("dfp_read and dfp_write asserted together");
      assert (!plru_update || ufp_resp) else $error("plru_update without ufp_resp");
      if (req_prev && !resp_prev)
        assert (ufp_read || ufp_write) else $error("request dropped before ufp_resp");
    end
    req_prev  = ufp_read | ufp_write;
    resp_prev = ufp_resp;
  end

  // Memory model: answers a held dfp request after DLY cycles
  int mcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      dfp_resp = 1'b0;
      mcnt = 0;
    end else begin
      if (dfp_resp) dfp_resp = 1'b0;
      if (dfp_read || dfp_write) begin
        mcnt++;
        if (mcnt == DLY) begin
          dfp_resp = 1'b1;
          mcnt = 0;
        end
      end
    end
  end

  // Datapath model: a filled way hits on the re-lookup
  initial forever begin
    @(negedge clk);
    if (!rst && |fill_we) begin
      #1;
      way_hit = fill_we;
    end
  end

  task automatic do_req(input logic wr, input logic [SI-1:0] set,
                        input logic [WAYS-1:0] hit0, valid, dirty, evict, exp_hv,
                        input int lat, input logic [WAYS-1:0] exp_fill, input logic exp_wb);
    resp_t e;
    bit    got;
    @(posedge clk);
    #1;
    way_hit = hit0; way_valid = valid; way_dirty = dirty; evict_candidate = evict;
    ufp_set = set;
    e.hv = exp_hv; e.we = wr ? exp_hv : '0; e.dirty = wr; e.set = set; e.lat = lat;
    resp_q.push_back(e);
    if (exp_fill != '0) fill_q.push_back(exp_fill);
    if (exp_wb) wb_q.push_back(exp_fill);
    req_cyc = cyc;
    ufp_read = !wr; ufp_write = wr;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = ufp_resp;
    end
    if (!got) chk("resp_timeout", 32'(got), 32'(1));
    #1;
    ufp_read = 1'b0; ufp_write = 1'b0;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ufp_resp", 32'(ufp_resp), 32'(0));
    chk("rst_dfp", 32'({dfp_read, dfp_write}), 32'(0));
    chk("rst_enables", 32'({data_we, fill_we, dirty_set, plru_update}), 32'(0));
    chk("rst_dfp_way", 32'(dfp_way), 32'(0));
    chk("rst_multi_hit", 32'(multi_hit), 32'(0));

    //     wr    set    hit0     valid    dirty    evict    exp_hv   lat        fill     wb
    do_req(1'b0, 4'd5,  4'b0100, 4'b1111, 4'b0000, 4'b0001, 4'b0100, 2,         4'b0000, 1'b0);
    do_req(1'b1, 4'd9,  4'b0001, 4'b1111, 4'b0000, 4'b0010, 4'b0001, 2,         4'b0000, 1'b0);
    do_req(1'b0, 4'd3,  4'b0000, 4'b0111, 4'b1000, 4'b1000, 4'b1000, 3 + DLY,   4'b1000, 1'b0);
    do_req(1'b1, 4'd12, 4'b0000, 4'b1111, 4'b0010, 4'b0010, 4'b0010, 3 + 2*DLY, 4'b0010, 1'b1);
    do_req(1'b1, 4'd6,  4'b0000, 4'b1111, 4'b1101, 4'b0010, 4'b0010, 3 + DLY,   4'b0010, 1'b0);
    chk("multi_hit_clear", 32'(multi_hit), 32'(0));
    do_req(1'b0, 4'd1,  4'b0110, 4'b1111, 4'b0000, 4'b0001, 4'b0010, 2,         4'b0000, 1'b0);
    @(negedge clk);
    chk("multi_hit_set", 32'(multi_hit), 32'(1));
    do_req(1'b1, 4'd15, 4'b1000, 4'b1111, 4'b0000, 4'b0001, 4'b1000, 2,         4'b0000, 1'b0);
    @(negedge clk);
    chk("multi_hit_sticky", 32'(multi_hit), 32'(1));

    // Reset while ALLOCATE is waiting on memory
    @(posedge clk);
    #1;
    way_hit = '0; way_valid = '0; way_dirty = '0; evict_candidate = 4'b0100; ufp_set = 4'd7;
    ufp_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = dfp_read;
    end
    chk("alloc_dfp_read", 32'(seen), 32'(1));
    chk("alloc_dfp_way", 32'(dfp_way), 32'(4'b0100));
    #1;
    rst = 1'b1; ufp_read = 1'b0;
    @(negedge clk);
    chk("midrst_dfp_read", 32'(dfp_read), 32'(0));
    chk("midrst_fill_we", 32'(fill_we), 32'(0));
    chk("midrst_dfp_way", 32'(dfp_way), 32'(0));
    chk("midrst_multi_hit", 32'(multi_hit), 32'(0));
    #1 rst = 1'b0;

    do_req(1'b0, 4'd2,  4'b0100, 4'b1111, 4'b0000, 4'b0001, 4'b0100, 2,         4'b0000, 1'b0);
    do_req(1'b0, 4'd8,  4'b0000, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 3 + 2*DLY, 4'b0001, 1'b1);
`ifdef CACHE_CTRL_PERF_EN
    @(negedge clk);
    chk("hit_count", hit_count, 32'd1);
    chk("miss_count", miss_count, 32'd1);
    chk("wb_count", wb_count, 32'd1);
`endif
    repeat (2) @(negedge clk);
    chk("resp_q_empty", 32'(resp_q.size()), 32'(0));
    chk("fill_q_empty", 32'(fill_q.size()), 32'(0));
    chk("wb_q_empty", 32'(wb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
